// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit and the execute stage.
package multdiv_pkg;

    // Number of datapath iterations for one 32-bit multiply or divide.
    localparam int ITER_DEFAULT = 32;

    // ALU opcodes that engage the multi-cycle unit.
    localparam logic [4:0] ALU_OP_MULT = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned magnitude of a two's-complement word; 0x80000000 maps to 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] value);
        return value[31] ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/multdiv_iter.sv
// Iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, one step per enable. The signed result and exception flag are
// presented combinationally from the step being taken, so the sequencer can
// register them on the final step.
module multdiv_iter
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        enable,
    input  logic        is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] step_result,
    output logic        step_exception
);

    // hi:lo is the product accumulator (mult) or remainder:quotient (div).
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dvsr;
    logic        neg;

    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [31:0] quo;

    // One iteration of the selected algorithm plus the sign fix-up of its outcome.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        hi_next        = hi;
        lo_next        = lo;
        step_result    = 32'd0;
        step_exception = 1'b0;

        add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : 33'd0);
        rem_shift = {hi, lo[31]};
        diff      = rem_shift - {1'b0, dvsr};

        if (is_div) begin
            hi_next = diff[32] ? rem_shift[31:0] : diff[31:0];
            lo_next = {lo[30:0], ~diff[32]};
        end else begin
            hi_next = add_sum[32:1];
            lo_next = {add_sum[0], lo[31:1]};
        end

        prod_mag = {hi_next, lo_next};
        prod     = neg ? (~prod_mag + 64'd1) : prod_mag;
        quo      = neg ? (~lo_next + 32'd1) : lo_next;

        if (is_div) begin
            // Only 0x80000000 / -1 yields a positive quotient that needs bit 31.
            step_result    = quo;
            step_exception = !neg && lo_next[31];
        end else begin
            step_result    = prod[31:0];
            step_exception = !((&prod[63:31]) || !(|prod[63:31]));
        end
    end

    // Operand capture on load, accumulator update on each enabled step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            hi   <= 32'd0;
            lo   <= 32'd0;
            dvsr <= 32'd0;
            neg  <= 1'b0;
        end else if (load) begin
            hi   <= 32'd0;
            lo   <= magnitude(operand_a);
            dvsr <= magnitude(operand_b);
            neg  <= operand_a[31] ^ operand_b[31];
        end else if (enable) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// Multi-cycle multiply/divide unit for the DX stage. Owns sequencing,
// pipeline stall generation and the result/exception registers.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alu_op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic [4:0]  result_rd,
    output logic        result_valid,
    output logic        exception
);

    state_t      state;
    logic [5:0]  count;
    logic        op_div;

    logic        op_is_mult;
    logic        op_is_div;
    logic        qualify;
    logic        div_zero;
    logic        last_step;
    logic        iter_load;
    logic        iter_enable;
    logic [31:0] step_result;
    logic        step_exception;

    assign op_is_mult  = (alu_op == ALU_OP_MULT);
    assign op_is_div   = (alu_op == ALU_OP_DIV);
    assign qualify     = start && (op_is_mult || op_is_div);
    assign div_zero    = op_is_div && (operandB == 32'd0);
    assign last_step   = (state == ST_RUN) && (count == 6'(ITER - 1));
    assign iter_load   = (state == ST_IDLE) && qualify && !div_zero;
    assign iter_enable = (state == ST_RUN);

    // Hold the front of the pipeline from the start cycle through the last RUN
    // cycle; released in DONE so the result is latched on the DONE edge.
    assign stall = !reset && (((state == ST_IDLE) && qualify) || (state == ST_RUN));

    multdiv_iter u_iter (
        .clock          (clock),
        .reset          (reset),
        .load           (iter_load),
        .enable         (iter_enable),
        .is_div         (op_div),
        .operand_a      (operandA),
        .operand_b      (operandB),
        .step_result    (step_result),
        .step_exception (step_exception)
    );

    // Sequencer FSM with registered busy/result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= 6'd0;
            op_div       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= 32'd0;
            result_rd    <= 5'd0;
            exception    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (qualify) begin
                        result_rd <= rd_in;
                        op_div    <= op_is_div;
                        count     <= 6'd0;
                        busy      <= 1'b1;
                        if (div_zero) begin
                            state        <= ST_DONE;
                            result       <= 32'd0;
                            exception    <= 1'b1;
                            result_valid <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    count <= count + 6'd1;
                    if (last_step) begin
                        state        <= ST_DONE;
                        result       <= step_result;
                        exception    <= step_exception;
                        result_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq.
module tb_multdiv_seq;

    localparam logic [4:0] OP_MULT = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  alu_op = 5'd0;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        result_valid;
    logic        exception;

    int checks = 0;
    int failures = 0;

    multdiv_seq #(.ITER(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .alu_op       (alu_op),
        .operandA     (operandA),
        .operandB     (operandB),
        .rd_in        (rd_in),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_rd    (result_rd),
        .result_valid (result_valid),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one operation and follows it until result_valid (bounded).
    // cycles counts posedges after the start cycle; stall_cnt includes the start cycle.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic seen, output int cycles,
                          output int stall_cnt, output logic [31:0] r, output logic [4:0] rrd,
                          output logic exc, output logic busy_done, output logic stall_done);
        seen = 0; cycles = 0; r = 0; rrd = 0; exc = 0; busy_done = 0; stall_done = 1;
        @(negedge clock);
        start = 1; alu_op = op; operandA = a; operandB = b; rd_in = rd;
        #1;
        stall_cnt = stall ? 1 : 0;
        while (!seen && cycles < 80) begin
            @(posedge clock);
            #1;
            start = 0; alu_op = 5'd0;
            operandA = 32'hDEAD_BEEF; operandB = 32'h1234_5678; rd_in = 5'd31;
            #1;
            cycles++;
            if (result_valid) begin
                seen = 1; r = result; rrd = result_rd; exc = exception;
                busy_done = busy; stall_done = stall;
            end else if (stall) begin
                stall_cnt++;
            end
        end
    endtask

    // Runs one op and checks result, rd, exception and latency.
    task automatic check_op(input string name, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_r,
                            input logic exp_exc, input int exp_cycles);
        logic seen, exc, busy_done, stall_done;
        int cycles, stall_cnt;
        logic [31:0] r;
        logic [4:0] rrd;
        run_op(op, a, b, rd, seen, cycles, stall_cnt, r, rrd, exc, busy_done, stall_done);
        checks++;
        if (seen !== 1'b1) begin
            failures++; $display("FAIL %s_valid: no result_valid within 80 cycles", name);
        end
        checks++;
        if (cycles !== exp_cycles) begin
            failures++; $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cycles, exp_cycles);
        end
        checks++;
        if (stall_cnt !== exp_cycles) begin
            failures++; $display("FAIL %s_stall: stall high %0d cycles, expected %0d", name, stall_cnt, exp_cycles);
        end
        checks++;
        if (r !== exp_r) begin
            failures++; $display("FAIL %s_result: got %h, expected %h", name, r, exp_r);
        end
        checks++;
        if (rrd !== rd) begin
            failures++; $display("FAIL %s_rd: got %0d, expected %0d", name, rrd, rd);
        end
        checks++;
        if (exc !== exp_exc) begin
            failures++; $display("FAIL %s_exception: got %b, expected %b", name, exc, exp_exc);
        end
        checks++;
        if (busy_done !== 1'b1 || stall_done !== 1'b0) begin
            failures++; $display("FAIL %s_done_flags: busy=%b stall=%b, expected busy=1 stall=0", name, busy_done, stall_done);
        end
        @(posedge clock);
        #2;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_pulse: result_valid=%b busy=%b after DONE, expected 0 0", name, result_valid, busy);
        end
        checks++;
        if (result !== exp_r) begin
            failures++; $display("FAIL %s_hold: result %h after DONE, expected %h", name, result, exp_r);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1; start = 1; alu_op = OP_MULT; operandA = 32'd3; operandB = 32'd4; rd_in = 5'd2;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl: stall=%b busy=%b valid=%b, expected 0 0 0", stall, busy, result_valid);
        end
        checks++;
        if (result !== 32'd0 || result_rd !== 5'd0 || exception !== 1'b0) begin
            failures++; $display("FAIL reset_data: result=%h rd=%0d exc=%b, expected 0 0 0", result, result_rd, exception);
        end
        @(posedge clock);
        @(negedge clock);
        start = 0; alu_op = 5'd0; reset = 0;
        @(posedge clock);
        #2;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL reset_start_discard: busy=%b stall=%b, expected 0 0", busy, stall);
        end
    endtask

    task automatic test_mult();
        check_op("mult_7x-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 33);
        check_op("mult_-5x-6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'd12, 32'd30, 1'b0, 33);
        check_op("mult_ovf", OP_MULT, 32'h4000_0000, 32'd4, 5'd1, 32'd0, 1'b1, 33);
    endtask

    task automatic test_div();
        check_op("div_100/7", OP_DIV, 32'd100, 32'd7, 5'd6, 32'd14, 1'b0, 33);
        check_op("div_-100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd8, 32'hFFFF_FFF2, 1'b0, 33);
        check_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 5'd9, 32'd0, 1'b1, 1);
        check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, 33);
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clock);
        start = 1; alu_op = OP_MULT; operandA = 32'd7; operandB = 32'd9; rd_in = 5'd3;
        @(posedge clock);
        #1;
        start = 0; alu_op = 5'd0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_immediate: stall=%b busy=%b, expected 0 0", stall, busy);
        end
        @(negedge clock);
        reset = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (result_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++; $display("FAIL abort_no_result: %0d result_valid pulses, expected 0", pulses);
        end
        check_op("after_abort", OP_MULT, 32'd12, 32'd11, 5'd7, 32'd132, 1'b0, 33);
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [31:0] r;
        logic [4:0] rrd;
        r = 0; rrd = 0; pulses = 0;
        @(negedge clock);
        start = 1; alu_op = OP_MULT; operandA = 32'd7; operandB = 32'hFFFF_FFFD; rd_in = 5'd5;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clock);
            #1;
            if (cyc >= 3 && cyc <= 20) begin
                start = 1; alu_op = OP_DIV; operandA = 32'd100; operandB = 32'd7; rd_in = 5'd9;
            end else begin
                start = 0; alu_op = 5'd0;
            end
            #1;
            if (result_valid) begin
                pulses++; r = result; rrd = result_rd;
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++; $display("FAIL b2b_pulses: %0d result_valid pulses, expected 1", pulses);
        end
        checks++;
        if (r !== 32'hFFFF_FFEB || rrd !== 5'd5) begin
            failures++; $display("FAIL b2b_payload: result=%h rd=%0d, expected ffffffeb 5", r, rrd);
        end
        checks++;
        if (result !== 32'hFFFF_FFEB || busy !== 1'b0) begin
            failures++; $display("FAIL b2b_hold: result=%h busy=%b, expected ffffffeb 0", result, busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter ITER, default 32: iteration count of the multi-cycle multiply/divide datapath.
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high; returns the block to IDLE immediately.
REQ-004 Port start  input  1  from DX stage: a mult/div instruction is present in DX this cycle.
REQ-005 Port alu_op  input  5  DX ALU opcode; 00110 = mult, 00111 = div; other values ignored.
REQ-006 Port operandA  input  32  signed multiplicand/dividend, post-bypass.
REQ-007 Port operandB  input  32  signed multiplier/divisor, post-bypass.
REQ-008 Port rd_in  input  5  destination register of the DX instruction.
REQ-009 Port stall  output  1  freezes PC, FD and DX latches while high.
REQ-010 Port busy  output  1  high whenever state is not IDLE.
REQ-011 Port result  output  32  signed product low word or quotient.
REQ-012 Port result_rd  output  5  destination captured at start.
REQ-013 Port result_valid  output  1  one-cycle pulse; DX->XM latch captures result/result_rd.
REQ-014 Port exception  output  1  valid only with result_valid; mult overflow, div-by-zero or div overflow.

Function
REQ-015 States: IDLE, RUN, DONE; state register plus a 6-bit iteration counter.
REQ-016 IDLE->RUN when start=1 and alu_op is mult or div; operands, op and rd_in captured at that edge (E0); counter cleared.
REQ-017 RUN: one datapath iteration per cycle; counter increments; RUN->DONE at the edge where counter reaches ITER-1.
REQ-018 Latency: result_valid is high in the cycle after edge E(ITER); with ITER=32 that is the 33rd cycle after the start cycle.
REQ-019 DONE->IDLE unconditionally after one cycle; result_valid=1 and busy=1 in DONE only.
REQ-020 stall = (state==IDLE and qualifying start) or state==RUN; stall=0 in DONE so the pipeline advances on the DONE edge.
REQ-021 start or alu_op changes while busy are ignored; no re-capture, no second result.
REQ-022 Multiply: 64-bit signed product; result = bits[31:0]; exception=1 when bits[63:31] are not all equal.
REQ-023 Divide: signed, truncate toward zero; remainder discarded.
REQ-024 Divisor 0: IDLE->DONE directly (result_valid one cycle after start cycle); result=0, exception=1.
REQ-025 0x80000000 / -1: full latency; result=0x80000000, exception=1.
REQ-026 result, result_rd and exception hold their last value outside DONE; the consumer uses them only under result_valid.

Reset
REQ-027 reset=1 forces state=IDLE, counter=0, stall=0, busy=0, result_valid=0, exception=0, result=0, result_rd=0, asynchronously.
REQ-028 reset mid-RUN aborts the operation; no result_valid is produced for it after reset deasserts.
REQ-029 start coincident with reset is discarded.

Structure
REQ-030 Package multdiv_pkg holds the state encoding, ITER default, and the ALU_OP_MULT/ALU_OP_DIV constants shared with the execute stage.
REQ-031 One sub-module, multdiv_iter: shift-add multiply / restoring divide, one step per enable, sign fix-up on the final step; multdiv_seq owns all sequencing.

Verification
REQ-032 mult 7 x -3, rd=5 -> stall high 33 cycles from the start cycle (start cycle through last RUN cycle), then result_valid pulse with result=-21, result_rd=5, exception=0.
REQ-033 div 100 / 7 -> result=14, exception=0; div -100 / 7 -> result=-14.
REQ-034 div 5 / 0 -> result_valid the cycle after start, result=0, exception=1, stall high for exactly 1 cycle.
REQ-035 mult 0x40000000 x 4 -> exception=1, result=0; div 0x80000000 / -1 -> result=0x80000000, exception=1.
REQ-036 reset pulsed at cycle 10 of RUN -> stall, busy drop immediately; no result_valid within 40 cycles; next start completes normally.
REQ-037 start re-asserted with new operands during RUN -> exactly one result_valid, carrying the originally captured operands and rd.
